ahb_sram_slave: RTL
===================

# ahb_sram_slave

AHB-Lite responder that terminates one of the Cortex-M3 bus masters (I-code, D-code or system bus) with a flop-based word-addressed memory. It supports byte, halfword and word accesses and programmable wait states. Illegal accesses get a two-cycle ERROR response. It sits behind the bus interconnect's `hsel` decode and gives the CPU wrapper a deterministic local memory for boot code, data and verification.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: number of 32-bit words; must be ≥ 1.
- `ADDR_WIDTH`, 12: width of the decoded byte-offset window. Only `haddr[ADDR_WIDTH-1:0]` is used.
- `WAIT_STATES`, 0: extra `hreadyout`-low cycles inserted in every OKAY data phase; legal range 0–15.

Ports:
- `clk` in 1: single clock, equal to the CPU `hclk`.
- `rst` in 1: asynchronous, active-high reset.
- `hsel` in 1: slave select from the interconnect.
- `haddr` in 32: address-phase byte address.
- `htrans` in 2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `hsize` in 3: 0=byte, 1=halfword, 2=word.
- `hburst` in 3: ignored; every beat is handled independently.
- `hprot` in 4: ignored.
- `hwrite` in 1: 1=write.
- `hwdata` in 32: write data, valid in the data phase.
- `hready` in 1: bus-wide HREADY, meaning the previous transfer has completed.
- `hreadyout` out 1: this slave's ready.
- `hresp` out 2: 00=OKAY, 01=ERROR.
- `hrdata` out 32: read data.

## Operation
- **Accept condition:** a transfer is accepted at a rising edge when `hsel & hready & htrans[1]`.
- **Latched fields:** at acceptance the block latches the word index `haddr[ADDR_WIDTH-1:2]`, the byte lanes, `hwrite` and the error flag.
- **IDLE/BUSY/unselected:** no access. Response is zero-wait OKAY.
- **Byte lanes** (little-endian):
  - byte: `4'b0001 << haddr[1:0]`
  - halfword: `4'b0011 << {haddr[1],1'b0}`
  - word: `4'b1111`
- **Illegal access:** any of the following.
  - `hsize > 2`
  - misalignment: halfword with `haddr[0]=1`, or word with `haddr[1:0]≠0`
  - word index ≥ `DEPTH_WORDS`
- **FSM states:**
  - `IDLE`: `hreadyout=1`, OKAY.
  - `WAIT`: `hreadyout=0`, OKAY. The wait counter is loaded with `WAIT_STATES` and decrements each cycle.
  - `DATA`: last OKAY cycle, `hreadyout=1`.
  - `ERR1`: `hreadyout=0`, `hresp=01`.
  - `ERR2`: `hreadyout=1`, `hresp=01`.
- **Transitions:**
  - accept, legal, `WAIT_STATES=0` → `DATA`
  - accept, legal, `WAIT_STATES>0` → `WAIT`
  - accept, illegal → `ERR1`
  - `WAIT` → `DATA` after the counter reaches 1
  - `ERR1` → `ERR2`
  - `DATA` or `ERR2` → next accept target if a new accept occurs at that edge; otherwise `IDLE`.
- **Write:** commits `hwdata` to the enabled lanes of the latched word at the edge that ends `DATA`. Unenabled lanes are unchanged.
- **Read:** `hrdata` is the latched word, driven combinationally during `WAIT`/`DATA` of a read. It is `32'h0` in all other states.
- **No write or read in error states:** `ERR1`/`ERR2` never write memory, and `hrdata=0` there.
- **Memory contents:** not reset.

## Timing
- **Reset values:** `hreadyout=1`, `hresp=00`, `hrdata=0`, FSM=`IDLE`, wait counter=0.
- **Reset mid-transfer:** the pending write is dropped and memory is unmodified.
- **Data-phase length:** OKAY data phase is `WAIT_STATES+1` cycles; ERROR response is exactly 2 cycles.
- **Pipelining:** a new address phase may be accepted at the same edge a data phase completes. There are no bubble cycles.
- **Read-after-write:** a read of the same word immediately following a write returns the new data.
- **Master-side stall:** `hready` low from another slave blocks acceptance. The address phase is re-sampled each cycle.
- **Error cancellation:** if the master drives IDLE in the `ERR2` cycle (ERROR cancellation), nothing is accepted.

## Configuration
- **`AHB_SRAM_ERR_CHECK_EN` defined:** illegal-access detection and the `ERR1`/`ERR2` states are compiled in, as described above.
- **Not defined:**
  - `hresp` is constant 00 and `ERR1`/`ERR2` are not built.
  - `hsize>2` is treated as a word access.
  - Misaligned addresses are force-aligned to `hsize`.
  - Out-of-range writes are discarded and out-of-range reads return `32'h0`, both with OKAY timing.

## Test plan
- **Reset:** assert `rst` mid-write with `WAIT_STATES=2` → `hreadyout=1`, `hresp=00`, `hrdata=0`; the target word is unchanged.
- **Byte write/readback:** with `WAIT_STATES=0`, word write `32'hDEADBEEF` to 0x10, then byte write `8'h55` to 0x12, then read 0x10 → `32'hDE55BEEF` in the cycle after the read address phase.
- **Wait states:** with `WAIT_STATES=3`, a back-to-back NONSEQ read then write → `hreadyout` low 3 cycles, high 1 cycle per transfer; no idle cycle between transfers.
- **Errors (macro on):** a word read to 0x2 and a write to index `DEPTH_WORDS` → `hresp=01` for 2 cycles with `hreadyout` sequence 0,1; memory unchanged; `hrdata=0`.
- **Errors (macro off):** same stimulus → OKAY; the 0x2 access is treated as 0x0; the out-of-range read returns 0.
- **Non-accepting cycles:** IDLE/BUSY, and NONSEQ with `hsel=0` or `hready=0` → no memory change; `hreadyout=1`, OKAY.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite responder backed by a flop-based, word-addressed memory.
// Latency: OKAY data phase lasts WAIT_STATES+1 cycles; ERROR response lasts 2 cycles.
// Backpressure: hreadyout low during wait states and ERR1; accepts only when bus hready is high.
// Optional: define AHB_SRAM_ERR_CHECK_EN to build illegal-access detection and ERROR responses.
module ahb_sram_slave #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA
`ifdef AHB_SRAM_ERR_CHECK_EN
    ,
    S_ERR1,
    S_ERR2
`endif
  } state_t;

  state_t state, state_nxt, acc_state;
  logic [3:0] cnt, cnt_nxt;

  logic [31:0] mem [DEPTH_WORDS];

  logic [MEM_AW-1:0] r_idx;
  logic [3:0]        r_lanes;
  logic              r_wr;
  logic              r_in_range;

  logic              accept;
  logic [IDX_W-1:0]  a_idx;
  logic              a_in_range;
  logic [3:0]        a_lanes;
  logic              unused_bits;

  // hburst/hprot carry no meaning for a single-port memory; upper address bits are decoded upstream.
  assign unused_bits = ^{hburst, hprot, haddr[31:ADDR_WIDTH], htrans[0]};

  assign accept     = hsel & hready & htrans[1];
  assign a_idx      = haddr[ADDR_WIDTH-1:2];
  assign a_in_range = ({{(32-IDX_W){1'b0}}, a_idx} < 32'(DEPTH_WORDS));

`ifdef AHB_SRAM_ERR_CHECK_EN
  logic a_err;
  assign a_err = (hsize > 3'd2)
               | ((hsize == 3'd1) & haddr[0])
               | ((hsize == 3'd2) & (haddr[1:0] != 2'b00))
               | ~a_in_range;
`endif

  // Little-endian byte lanes; the low address bits below the access size are ignored, which force-aligns.
  always_comb begin
    a_lanes = 4'b1111;
    case (hsize)
      3'd0:    a_lanes = 4'b0001 << haddr[1:0];
      3'd1:    a_lanes = 4'b0011 << {haddr[1], 1'b0};
      default: a_lanes = 4'b1111;
    endcase
  end

  // Capture the address-phase fields that the data phase needs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= '0;
      r_lanes    <= '0;
      r_wr       <= 1'b0;
      r_in_range <= 1'b0;
    end else if (accept) begin
      r_idx      <= haddr[MEM_AW+1:2];
      r_lanes    <= a_lanes;
      r_wr       <= hwrite;
      r_in_range <= a_in_range;
    end
  end

  // State and wait-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, wait counter and response outputs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hreadyout = 1'b1;
    hresp     = 2'b00;
    acc_state = (WS == 4'd0) ? S_DATA : S_WAIT;
`ifdef AHB_SRAM_ERR_CHECK_EN
    if (a_err) acc_state = S_ERR1;
`endif
    case (state)
      S_WAIT: begin
        hreadyout = 1'b0;
        cnt_nxt   = cnt - 4'd1;
        if (cnt <= 4'd1) state_nxt = S_DATA;
      end
`ifdef AHB_SRAM_ERR_CHECK_EN
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 2'b01;
        state_nxt = S_ERR2;
      end
      S_ERR2: begin
        hresp     = 2'b01;
        state_nxt = accept ? acc_state : S_IDLE;
      end
`endif
      default: state_nxt = accept ? acc_state : S_IDLE;
    endcase
    // A fresh OKAY transfer entering WAIT starts a full wait count.
    if (state_nxt == S_WAIT && state != S_WAIT) cnt_nxt = WS;
  end

  // Read data is only presented during the OKAY data phase of an in-range read.
  assign hrdata = ((state == S_WAIT || state == S_DATA) && !r_wr && r_in_range) ? mem[r_idx] : 32'h0;

  // Commit enabled byte lanes at the edge that ends the write data phase; reset drops it.
  always_ff @(posedge clk) begin
    if (!rst && state == S_DATA && r_wr && r_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (r_lanes[b]) mem[r_idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

endmodule
